pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage MIPS pipeline.
- Evaluates load-use, multiply/divide-unit (MDU) and data-memory-wait hazards, plus taken branches resolved in EX.
- Drives the stall inputs of the sreggy IF/ID, ID/EX and EX/MEM pipeline registers, the PC hold, and the per-stage NOP-insert (flush) controls.
- Tracks MDU occupancy with an internal countdown and keeps a saturating stall-cycle performance counter.

Parameters:
- REGW, 5, register index width.
- MDU_LAT, 32, MDU latency in cycles from accepted start to result readable (must be >= 1).
- CW, 6, MDU counter width; must satisfy 2^CW > MDU_LAT.

Ports:
- clk  input  1  clock; all state updates on posedge clk.
- reset  input  1  synchronous, active-high reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_rs  input  REGW  ID source register rs.
- id_rt  input  REGW  ID source register rt.
- id_uses_rt  input  1  ID instruction reads rt.
- id_mdu_read  input  1  ID instruction is mfhi/mflo.
- ex_memread  input  1  EX instruction is a load.
- ex_rt  input  REGW  load destination in EX.
- ex_mdu_start  input  1  EX instruction is mult/multu/div/divu.
- ex_branch_taken  input  1  branch/jump in EX resolved taken.
- mem_req  input  1  MEM stage accessing data memory.
- mem_ready  input  1  data memory completes this cycle.
- stall_pc  output  1  hold PC.
- stall_ifid  output  1  hold IF/ID.
- stall_idex  output  1  hold ID/EX.
- stall_exmem  output  1  hold EX/MEM.
- flush_ifid  output  1  load NOP into IF/ID.
- flush_idex  output  1  load NOP into ID/EX.
- flush_exmem  output  1  load NOP into EX/MEM.
- flush_memwb  output  1  load NOP into MEM/WB.
- mdu_busy  output  1  MDU result not yet available.
- stall_cycles  output  32  count of cycles with stall_pc=1.

Behaviour:
- Reset:
  - While reset=1, all stall_* and flush_* outputs are forced to 0.
  - On the clock edge: state←RUN, mdu_cnt←0, stall_cycles←0.
  - A reset asserted mid-MDU operation abandons the operation.
- Timing: stall/flush outputs are combinational from the current inputs and registered state, so there is zero-cycle latency. mdu_busy = (state==MDU_BUSY), i.e. it is registered.
- Hazard terms:
  - mem_wait = mem_req & ~mem_ready.
  - load_use = ex_memread & (ex_rt!=0) & id_valid & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
  - mdu_rd = id_valid & id_mdu_read & (mdu_busy | ex_mdu_start).
  - mdu_struct = ex_mdu_start & mdu_busy.
- Priority, highest first; exactly one action applies per cycle:
  1. mem_wait: stall_pc, stall_ifid, stall_idex, stall_exmem = 1; flush_memwb = 1. A branch in EX is held and re-evaluated next cycle.
  2. ex_branch_taken: flush_ifid = 1, flush_idex = 1. This suppresses any concurrent load_use or mdu_rd, because that instruction is wrong-path.
  3. mdu_struct: stall_pc, stall_ifid, stall_idex = 1; flush_exmem = 1.
  4. load_use or mdu_rd: stall_pc, stall_ifid = 1; flush_idex = 1.
  5. Otherwise all outputs are 0.
- FSM (RUN, MDU_BUSY) and mdu_cnt:
  - A start is accepted when ex_mdu_start=1, reset=0, and neither mem_wait, ex_branch_taken nor mdu_struct applies.
  - On accept with MDU_LAT>1: mdu_cnt←MDU_LAT-1, state←MDU_BUSY.
  - On accept with MDU_LAT==1: state stays RUN and mdu_busy never rises.
  - In MDU_BUSY, mdu_cnt decrements every cycle regardless of pipeline stalls. When mdu_cnt==1: mdu_cnt←0, state←RUN.
- stall_cycles:
  - Increments on each cycle with stall_pc=1 and reset=0.
  - Saturates at 32'hFFFF_FFFF (no wrap).
- Register $0 never causes a load-use stall.

Decomposition:
- Shared package/header (ifndef-guarded include):
  - FSM state encodings ST_RUN=1'b0, ST_MDU_BUSY=1'b1.
  - Default MDU_LAT constant.
- Sub-module: mdu_countdown, containing the loadable down-counter and busy flag, parameterised by CW.
- Hazard decode and priority mux stay in the top level.

Test Plan:
- Load-use: ex_memread=1, ex_rt=8, id_rs=8, id_valid=1 → stall_pc=stall_ifid=flush_idex=1 for exactly 1 cycle; stall_cycles 0→1. Repeat with ex_rt=0 → no stall.
- MDU: MDU_LAT=4; accept start at cycle 0 → mdu_busy=1 in cycles 1–3 and 0 at cycle 4. mfhi in ID at cycle 1 → front-end stalled for cycles 1–3 and released at cycle 4.
- Structural: second ex_mdu_start while mdu_busy → stall_idex=flush_exmem=1 until the cycle mdu_busy falls; the new start is accepted that cycle and mdu_busy is 1 next cycle.
- Priorities:
  - ex_branch_taken and load_use together → flush_ifid=flush_idex=1, stall_pc=0.
  - mem_req=1, mem_ready=0 for 3 cycles with branch in EX → all four stalls + flush_memwb for 3 cycles, then the branch flush on the 4th cycle.
- Reset mid-MDU (mdu_cnt=20): reset for 1 cycle → mdu_busy=0, stall_cycles=0, all stall/flush=0 during reset.
- Saturation: force 2^32+5 stall cycles (or preload via hierarchy to 32'hFFFF_FFFE) → stall_cycles holds 32'hFFFF_FFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared definitions for the pipeline hazard controller:
//   - MDU tracker FSM state encodings
//   - default MDU latency
//   - packed control-bundle type and one constant per scheduler action
// No ports (package).
// -----------------------------------------------------------------------------
`ifndef PIPE_HAZARD_CTRL_PKG_SV
`define PIPE_HAZARD_CTRL_PKG_SV

package pipe_hazard_ctrl_pkg;

    // MDU tracker states
    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MDU_BUSY = 1'b1;

    // Cycles from an accepted mult/div start until HI/LO are readable
    localparam int MDU_LAT_DEFAULT = 32;

    // Stall and NOP-insert controls, one bundle per cycle
    typedef struct packed {
        logic stall_pc;
        logic stall_ifid;
        logic stall_idex;
        logic stall_exmem;
        logic flush_ifid;
        logic flush_idex;
        logic flush_exmem;
        logic flush_memwb;
    } ctrl_t;

    // Nothing held, nothing squashed
    localparam ctrl_t CTRL_NONE      = '{default: 1'b0};
    // Data memory not done: freeze everything up to MEM, bubble into WB
    localparam ctrl_t CTRL_MEM_WAIT  = '{stall_pc: 1'b1, stall_ifid: 1'b1,
                                         stall_idex: 1'b1, stall_exmem: 1'b1,
                                         flush_memwb: 1'b1, default: 1'b0};
    // Taken branch in EX: squash the two wrong-path instructions behind it
    localparam ctrl_t CTRL_BRANCH    = '{flush_ifid: 1'b1, flush_idex: 1'b1,
                                         default: 1'b0};
    // MDU already busy: keep the new mult/div in EX, bubble into MEM
    localparam ctrl_t CTRL_MDU_STRUCT = '{stall_pc: 1'b1, stall_ifid: 1'b1,
                                          stall_idex: 1'b1, flush_exmem: 1'b1,
                                          default: 1'b0};
    // Data dependency at ID: hold front end, bubble into EX
    localparam ctrl_t CTRL_ID_HOLD   = '{stall_pc: 1'b1, stall_ifid: 1'b1,
                                         flush_idex: 1'b1, default: 1'b0};

endpackage

`endif

// File: rtl/pipe_hazard_ctrl_mdu_countdown.sv
// -----------------------------------------------------------------------------
// mdu_countdown
// Tracks multiply/divide unit occupancy. A load starts a countdown from
// i_load_val; the unit stays busy until the count reaches 1, then returns
// to RUN on the following edge. The count keeps running whatever the
// pipeline does, because the MDU itself never stalls.
// Ports:
//   clk         clock
//   i_reset     synchronous active-high reset (abandons any operation)
//   i_load      accept a new operation (only honoured in RUN)
//   i_load_val  initial count (MDU latency - 1)
//   o_busy      registered busy flag (state == ST_MDU_BUSY)
//   o_state     current FSM state, for observation
// -----------------------------------------------------------------------------
module mdu_countdown
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          i_reset,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    output logic          o_busy,
    output logic [0:0]    o_state
);

    logic [0:0]    r_state;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (i_load) begin
                        r_cnt   <= i_load_val;
                        r_state <= ST_MDU_BUSY;
                    end
                end
                ST_MDU_BUSY: begin
                    if (r_cnt == CW'(1)) begin
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
            endcase
        end
    end

    assign o_busy  = (r_state == ST_MDU_BUSY);
    assign o_state = r_state;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall/flush scheduler for the 5-stage MIPS pipeline. Detects
// data-memory wait, taken branch in EX, MDU structural conflict, load-use and
// MDU-read hazards, and drives pipeline-register holds and NOP inserts with
// zero-cycle latency. Exactly one action applies per cycle, highest first:
// mem_wait, branch, mdu_struct, load_use/mdu_rd.
//
// Handshake note: there is no valid/ready pair here; the stall outputs act as
// a "not ready" back to earlier stages, and a stage whose register is held
// keeps presenting the same instruction until the stall drops.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   id_*                ID-stage instruction info (valid, rs, rt, uses_rt,
//                       mfhi/mflo)
//   ex_memread, ex_rt   load in EX and its destination
//   ex_mdu_start        mult/div in EX
//   ex_branch_taken     branch/jump resolved taken in EX
//   mem_req, mem_ready  data memory access in MEM and its completion
//   stall_*             hold PC / IF-ID / ID-EX / EX-MEM
//   flush_*             load NOP into IF-ID / ID-EX / EX-MEM / MEM-WB
//   mdu_busy            MDU result not yet available (registered)
//   stall_cycles        saturating count of cycles with stall_pc=1
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REGW    = 5,
    parameter int MDU_LAT = MDU_LAT_DEFAULT,  // >= 1
    parameter int CW      = 6                 // 2**CW > MDU_LAT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic            id_uses_rt,
    input  logic            id_mdu_read,
    input  logic            ex_memread,
    input  logic [REGW-1:0] ex_rt,
    input  logic            ex_mdu_start,
    input  logic            ex_branch_taken,
    input  logic            mem_req,
    input  logic            mem_ready,
    output logic            stall_pc,
    output logic            stall_ifid,
    output logic            stall_idex,
    output logic            stall_exmem,
    output logic            flush_ifid,
    output logic            flush_idex,
    output logic            flush_exmem,
    output logic            flush_memwb,
    output logic            mdu_busy,
    output logic [31:0]     stall_cycles
);

    // With a single-cycle MDU the result is ready before any consumer can
    // reach ID, so the tracker is never armed.
    localparam bit            MDU_MULTI_CYCLE = (MDU_LAT > 1);
    localparam logic [CW-1:0] MDU_LOAD_VAL    = CW'(MDU_LAT - 1);

    logic        w_mem_wait;
    logic        w_load_use;
    logic        w_mdu_rd;
    logic        w_mdu_struct;
    logic        w_accept;
    logic        w_mdu_busy;
    logic [0:0]  w_mdu_state;
    ctrl_t       w_ctrl;
    logic [31:0] r_stall_cycles;

    // ---------------- hazard decode ----------------
    assign w_mem_wait   = mem_req & ~mem_ready;
    // $0 is hard-wired zero, so a load "into" it produces nothing to wait for
    assign w_load_use   = ex_memread & (ex_rt != '0) & id_valid &
                          ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
    // A start still in EX will occupy the MDU next cycle, so mfhi/mflo behind
    // it must wait just like behind a running operation.
    assign w_mdu_rd     = id_valid & id_mdu_read & (w_mdu_busy | ex_mdu_start);
    assign w_mdu_struct = ex_mdu_start & w_mdu_busy;

    // ---------------- priority mux ----------------
    always_comb begin
        w_ctrl = CTRL_NONE;
        if (!reset) begin
            if (w_mem_wait) begin
                w_ctrl = CTRL_MEM_WAIT;
            end else if (ex_branch_taken) begin
                // Anything in ID is wrong-path; its hazards are irrelevant
                w_ctrl = CTRL_BRANCH;
            end else if (w_mdu_struct) begin
                w_ctrl = CTRL_MDU_STRUCT;
            end else if (w_load_use || w_mdu_rd) begin
                w_ctrl = CTRL_ID_HOLD;
            end
        end
    end

    assign stall_pc    = w_ctrl.stall_pc;
    assign stall_ifid  = w_ctrl.stall_ifid;
    assign stall_idex  = w_ctrl.stall_idex;
    assign stall_exmem = w_ctrl.stall_exmem;
    assign flush_ifid  = w_ctrl.flush_ifid;
    assign flush_idex  = w_ctrl.flush_idex;
    assign flush_exmem = w_ctrl.flush_exmem;
    assign flush_memwb = w_ctrl.flush_memwb;

    // ---------------- MDU occupancy ----------------
    // A start moves on only when EX actually advances this cycle.
    assign w_accept = ex_mdu_start & ~reset & ~w_mem_wait &
                      ~ex_branch_taken & ~w_mdu_struct;

    mdu_countdown #(
        .CW(CW)
    ) u_mdu_countdown (
        .clk        (clk),
        .i_reset    (reset),
        .i_load     (w_accept & MDU_MULTI_CYCLE),
        .i_load_val (MDU_LOAD_VAL),
        .o_busy     (w_mdu_busy),
        .o_state    (w_mdu_state)
    );

    assign mdu_busy = (w_mdu_state == ST_MDU_BUSY) & w_mdu_busy;

    // ---------------- stall-cycle counter ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (stall_pc && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;

endmodule
